// File: rtl/uart_tx_pkg.sv
// Shared UART framing constants, FSM state encodings and a clog2 helper.
package uart_tx_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned BIT_IDX_W = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Ceiling log2, minimum 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each bit.
module uart_baud_tick
   import uart_tx_pkg::*;
#(
   parameter int unsigned DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Next count; tick is pre-computed so it is high exactly while cnt_q == DIV-1.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clear || (cnt_q == CW'(DIV - 1))) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      tick_d = (cnt_d == CW'(DIV - 1));
   end

   // Counter and tick registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: wr/tbe handshake in, 8N1 LSB-first serial out on txd.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned BAUD   = 9600
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 wr,
   output logic                 tbe,
   output logic                 txd
);

   localparam int unsigned DIV = CLK_HZ / BAUD;

   if (DIV < 2) begin : g_div_check
      $error("uart_tx: CLK_HZ/BAUD must be at least 2");
   end

   logic [1:0]           state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic                 wr_q, wr_d;
   logic                 txd_q, txd_d;
   logic                 tbe_q, tbe_d;
   logic                 tick;
   logic                 baud_clear;

   // Timer held at zero while idle so each frame is phase-aligned to its request.
   assign baud_clear = (state_q == ST_IDLE);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (baud_clear),
      .tick  (tick)
   );

   // Next-state, shift register and registered-output decode.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      wr_d      = wr;
      txd_d     = 1'b1;
      tbe_d     = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (wr && !wr_q) begin
               shift_d = data_in;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
               if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (tick) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs reflect the state being entered, so they line up with it.
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[0];
         default:  txd_d = 1'b1;
      endcase
      tbe_d = (state_d == ST_IDLE);
   end

   // State and output registers; wr_q resets high so a held wr cannot start a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         wr_q      <= 1'b1;
         txd_q     <= 1'b1;
         tbe_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         wr_q      <= wr_d;
         txd_q     <= txd_d;
         tbe_q     <= tbe_d;
      end
   end

   assign txd = txd_q;
   assign tbe = tbe_q;

endmodule
